accumulator_write_arbiter: RTL and testbench

Arbitrates write requests from several producers (multiplier-array output lanes, neighbor-exchange input ports) onto the banked accumulator buffer, which accepts at most one write per bank per cycle. Each bank has its own round-robin arbiter; losers are back-pressured with valid/ready. Granted writes are registered and presented to the buffer's per-bank write ports one cycle after acceptance. A saturating stall counter supports performance profiling.

---
 rtl/accumulator_write_arbiter_if.sv | 65 ++++++
 rtl/accumulator_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_accumulator_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// accumulator_write_arbiter_if
//
// Purpose:
//   Bundles the write-request handshake from the producers (multiplier lanes,
//   neighbor-exchange ports) and the registered per-bank write ports that
//   feed the banked accumulator buffer.
//
// Signals:
//   req_valid[REQUESTERS]          request present
//   req_bank[REQUESTERS]           target bank
//   req_entry[REQUESTERS]          target entry within the bank
//   req_data[REQUESTERS]           write data
//   req_ready[REQUESTERS]          grant back to the requester
//   bank_write_enable[BANK_COUNT]  registered write strobe per bank
//   bank_entry[BANK_COUNT]         registered write entry per bank
//   bank_data[BANK_COUNT]          registered write data per bank
//
// Modports:
//   master  environment side: drives requests, observes grants/bank writes
//   slave   arbiter side: consumes requests, drives grants/bank writes
// ----------------------------------------------------------------------------
interface accumulator_write_arbiter_if #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 128,
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 8
) ();

    localparam int BANK_W  = $clog2(BANK_COUNT);
    localparam int ENTRY_W = $clog2(TILE_SIZE);

    logic                  req_valid         [REQUESTERS];
    logic [BANK_W-1:0]     req_bank          [REQUESTERS];
    logic [ENTRY_W-1:0]    req_entry         [REQUESTERS];
    logic [DATA_WIDTH-1:0] req_data          [REQUESTERS];
    logic                  req_ready         [REQUESTERS];

    logic                  bank_write_enable [BANK_COUNT];
    logic [ENTRY_W-1:0]    bank_entry        [BANK_COUNT];
    logic [DATA_WIDTH-1:0] bank_data         [BANK_COUNT];

    modport master (
        output req_valid,
        output req_bank,
        output req_entry,
        output req_data,
        input  req_ready,
        input  bank_write_enable,
        input  bank_entry,
        input  bank_data
    );

    modport slave (
        input  req_valid,
        input  req_bank,
        input  req_entry,
        input  req_data,
        output req_ready,
        output bank_write_enable,
        output bank_entry,
        output bank_data
    );

endinterface

// File: rtl/accumulator_write_arbiter.sv
// ----------------------------------------------------------------------------
// accumulator_write_arbiter
//
// Purpose:
//   Arbitrates write requests from several producers onto the banked
//   accumulator buffer, which takes at most one write per bank per cycle.
//   Every bank owns an independent round-robin arbiter; losers simply see
//   req_ready low and hold their request. Granted writes are registered and
//   presented on the bank's write port one cycle after acceptance.
//   A saturating counter records cycles in which any request was held off.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   arb_enable   1 = grants allowed, 0 = every req_ready held low
//   stall_clear  synchronous clear of stall_count (wins over increment)
//   stall_count  saturating count of cycles with a back-pressured request
//   idle         no request pending and no bank write strobe active
//   bus          request handshake and per-bank write ports (slave side)
// ----------------------------------------------------------------------------
module accumulator_write_arbiter #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 128,
    parameter int REQUESTERS = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arb_enable,
    input  logic        stall_clear,
    output logic [15:0] stall_count,
    output logic        idle,
    accumulator_write_arbiter_if.slave bus
);

    localparam int BANK_W = $clog2(BANK_COUNT);
    localparam int PTR_W  = $clog2(REQUESTERS);

    // Round-robin pointer per bank: the requester searched first next cycle.
    logic [PTR_W-1:0] ptr         [BANK_COUNT];
    logic [PTR_W-1:0] next_ptr    [BANK_COUNT];

    // Winner of this cycle's arbitration for each bank.
    logic             grant_valid [BANK_COUNT];
    logic [PTR_W-1:0] grant_idx   [BANK_COUNT];

    logic             any_stall;

    // Requester index reached after stepping 'offset' places past 'start',
    // wrapping from REQUESTERS-1 back to 0. Works for non power-of-two counts.
    function automatic logic [PTR_W-1:0] rr_index(input int start, input int offset);
        int sum;
        sum = start + offset;
        if (sum >= REQUESTERS) begin
            sum = sum - REQUESTERS;
        end
        return PTR_W'(sum);
    endfunction

    // Per-bank round-robin search. Scanning from ptr upward, the first
    // requester that is valid and targets this bank wins. Nothing is granted
    // while arb_enable is low, which also freezes the pointers.
    always_comb begin
        for (int b = 0; b < BANK_COUNT; b++) begin
            grant_valid[b] = 1'b0;
            grant_idx[b]   = '0;
        end
        if (arb_enable) begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                for (int i = 0; i < REQUESTERS; i++) begin
                    if (!grant_valid[b]
                        && bus.req_valid[rr_index(int'(ptr[b]), i)]
                        && (bus.req_bank[rr_index(int'(ptr[b]), i)] == BANK_W'(b))) begin
                        grant_valid[b] = 1'b1;
                        grant_idx[b]   = rr_index(int'(ptr[b]), i);
                    end
                end
            end
        end
    end

    // Pointer advances to one past the winner so the winner becomes the
    // lowest-priority candidate on the following contested cycle.
    always_comb begin
        for (int b = 0; b < BANK_COUNT; b++) begin
            next_ptr[b] = '0;
            if (grant_idx[b] != PTR_W'(REQUESTERS - 1)) begin
                next_ptr[b] = grant_idx[b] + PTR_W'(1);
            end
        end
    end

    // A requester targets exactly one bank, so it can win at most one bank
    // arbitration; its ready is just the OR of grants that name it.
    always_comb begin
        for (int r = 0; r < REQUESTERS; r++) begin
            bus.req_ready[r] = 1'b0;
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (grant_valid[b]) begin
                bus.req_ready[grant_idx[b]] = 1'b1;
            end
        end
    end

    // A cycle counts as stalled when any valid request is not accepted,
    // including every pending request while arbitration is disabled.
    always_comb begin
        any_stall = 1'b0;
        for (int r = 0; r < REQUESTERS; r++) begin
            if (bus.req_valid[r] && !bus.req_ready[r]) begin
                any_stall = 1'b1;
            end
        end
    end

    // Idle only when nothing is requested and no write is on its way out.
    always_comb begin
        idle = 1'b1;
        for (int r = 0; r < REQUESTERS; r++) begin
            if (bus.req_valid[r]) begin
                idle = 1'b0;
            end
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (bus.bank_write_enable[b]) begin
                idle = 1'b0;
            end
        end
    end

    // Output register stage and pointer update. Entry/data keep their last
    // value when a bank has no grant; only the strobe drops. Reset discards
    // any write still sitting in the register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                ptr[b]                   <= '0;
                bus.bank_write_enable[b] <= 1'b0;
                bus.bank_entry[b]        <= '0;
                bus.bank_data[b]         <= '0;
            end
        end else begin
            for (int b = 0; b < BANK_COUNT; b++) begin
                bus.bank_write_enable[b] <= grant_valid[b];
                if (grant_valid[b]) begin
                    ptr[b]            <= next_ptr[b];
                    bus.bank_entry[b] <= bus.req_entry[grant_idx[b]];
                    bus.bank_data[b]  <= bus.req_data[grant_idx[b]];
                end
            end
        end
    end

    // Saturating stall counter; a clear in the same cycle as a stall wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_clear) begin
            stall_count <= '0;
        end else if (any_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_accumulator_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_accumulator_write_arbiter
//
// Directed scenarios for the accumulator write arbiter: reset state, single
// write latency, round-robin order on one bank, parallel grants on distinct
// banks, arbitration disable, stall counter saturation/clear, and reset
// dropping an in-flight write.
// ----------------------------------------------------------------------------
module tb_accumulator_write_arbiter;

    localparam int BANK_COUNT = 32;
    localparam int TILE_SIZE  = 128;
    localparam int REQUESTERS = 4;
    localparam int DATA_WIDTH = 8;
    localparam int BANK_W     = $clog2(BANK_COUNT);
    localparam int ENTRY_W    = $clog2(TILE_SIZE);

    logic        clk;
    logic        reset;
    logic        arb_enable;
    logic        stall_clear;
    logic [15:0] stall_count;
    logic        idle;

    int check_count = 0;
    int pass_count  = 0;

    accumulator_write_arbiter_if #(
        .BANK_COUNT(BANK_COUNT),
        .TILE_SIZE (TILE_SIZE),
        .REQUESTERS(REQUESTERS),
        .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    accumulator_write_arbiter #(
        .BANK_COUNT(BANK_COUNT),
        .TILE_SIZE (TILE_SIZE),
        .REQUESTERS(REQUESTERS),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arb_enable (arb_enable),
        .stall_clear(stall_clear),
        .stall_count(stall_count),
        .idle       (idle),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [REQUESTERS-1:0] ready_vec();
        logic [REQUESTERS-1:0] v;
        for (int r = 0; r < REQUESTERS; r++) v[r] = bus.req_ready[r];
        return v;
    endfunction

    function automatic logic [BANK_COUNT-1:0] strobe_vec();
        logic [BANK_COUNT-1:0] v;
        for (int b = 0; b < BANK_COUNT; b++) v[b] = bus.bank_write_enable[b];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_requests();
        for (int r = 0; r < REQUESTERS; r++) begin
            bus.req_valid[r] = 1'b0;
            bus.req_bank[r]  = '0;
            bus.req_entry[r] = '0;
            bus.req_data[r]  = '0;
        end
    endtask

    task automatic drive(input int r, input int bank, input int entry, input logic [7:0] data);
        bus.req_valid[r] = 1'b1;
        bus.req_bank[r]  = BANK_W'(bank);
        bus.req_entry[r] = ENTRY_W'(entry);
        bus.req_data[r]  = data;
    endtask

    task automatic test_reset();
        logic any_entry;
        logic any_data;
        reset       = 1'b1;
        arb_enable  = 1'b1;
        stall_clear = 1'b0;
        clear_requests();
        #1;
        any_entry = 1'b0;
        any_data  = 1'b0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (bus.bank_entry[b] != '0) any_entry = 1'b1;
            if (bus.bank_data[b]  != '0) any_data  = 1'b1;
        end
        check_count++;
        if (strobe_vec() !== 32'h0) $display("[TB] FAIL reset_strobes: got %h expected %h", strobe_vec(), 32'h0);
        else pass_count++;
        check_count++;
        if (any_entry !== 1'b0 || any_data !== 1'b0) $display("[TB] FAIL reset_entry_data: nonzero entry=%b data=%b expected 0/0", any_entry, any_data);
        else pass_count++;
        check_count++;
        if (stall_count !== 16'h0) $display("[TB] FAIL reset_stall: got %h expected %h", stall_count, 16'h0);
        else pass_count++;
        check_count++;
        if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b expected 1", idle);
        else pass_count++;
        // ready stays combinational during reset
        drive(0, 6, 1, 8'h11);
        #1;
        check_count++;
        if (ready_vec() !== 4'b0001) $display("[TB] FAIL reset_ready_comb: got %b expected 0001", ready_vec());
        else pass_count++;
        check_count++;
        if (idle !== 1'b0) $display("[TB] FAIL reset_idle_busy: got %b expected 0", idle);
        else pass_count++;
        clear_requests();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        drive(0, 5, 17, 8'hA3);
        #1;
        check_count++;
        if (ready_vec() !== 4'b0001) $display("[TB] FAIL single_ready: got %b expected 0001", ready_vec());
        else pass_count++;
        step();
        clear_requests();
        #1;
        check_count++;
        if (strobe_vec() !== 32'h0000_0020) $display("[TB] FAIL single_strobe: got %h expected %h", strobe_vec(), 32'h20);
        else pass_count++;
        check_count++;
        if (bus.bank_entry[5] !== 7'd17) $display("[TB] FAIL single_entry: got %0d expected 17", bus.bank_entry[5]);
        else pass_count++;
        check_count++;
        if (bus.bank_data[5] !== 8'hA3) $display("[TB] FAIL single_data: got %h expected a3", bus.bank_data[5]);
        else pass_count++;
        check_count++;
        if (idle !== 1'b0) $display("[TB] FAIL single_idle_strobe: got %b expected 0", idle);
        else pass_count++;
        step();
        check_count++;
        if (strobe_vec() !== 32'h0) $display("[TB] FAIL single_pulse_end: got %h expected 0", strobe_vec());
        else pass_count++;
        check_count++;
        if (idle !== 1'b1 || stall_count !== 16'h0) $display("[TB] FAIL single_idle_stall: got idle=%b stall=%0d expected 1/0", idle, stall_count);
        else pass_count++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [7:0] exp_data;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int r = 0; r < REQUESTERS; r++) drive(r, 2, r + 4, 8'hC0 | 8'(r));
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_ready = 4'b0001 << (k % 4);
            exp_data  = 8'hC0 | 8'(k % 4);
            check_count++;
            if (ready_vec() !== exp_ready) $display("[TB] FAIL rr_ready_%0d: got %b expected %b", k, ready_vec(), exp_ready);
            else pass_count++;
            step();
            check_count++;
            if (strobe_vec() !== 32'h4 || bus.bank_data[2] !== exp_data || bus.bank_entry[2] !== 7'((k % 4) + 4))
                $display("[TB] FAIL rr_write_%0d: got strobe=%h data=%h entry=%0d expected 4/%h/%0d",
                         k, strobe_vec(), bus.bank_data[2], bus.bank_entry[2], exp_data, (k % 4) + 4);
            else pass_count++;
        end
        check_count++;
        if (stall_count !== 16'd8) $display("[TB] FAIL rr_stall: got %0d expected 8", stall_count);
        else pass_count++;
        clear_requests();
        step();
    endtask

    task automatic test_distinct_banks();
        int banks [4] = '{0, 1, 31, 7};
        logic [7:0] datas [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int r = 0; r < 4; r++) drive(r, banks[r], r + 1, datas[r]);
        #1;
        check_count++;
        if (ready_vec() !== 4'b1111) $display("[TB] FAIL distinct_ready: got %b expected 1111", ready_vec());
        else pass_count++;
        step();
        clear_requests();
        check_count++;
        if (strobe_vec() !== 32'h8000_0083) $display("[TB] FAIL distinct_strobes: got %h expected 80000083", strobe_vec());
        else pass_count++;
        for (int r = 0; r < 4; r++) begin
            check_count++;
            if (bus.bank_data[banks[r]] !== datas[r] || bus.bank_entry[banks[r]] !== 7'(r + 1))
                $display("[TB] FAIL distinct_bank%0d: got data=%h entry=%0d expected %h/%0d",
                         banks[r], bus.bank_data[banks[r]], bus.bank_entry[banks[r]], datas[r], r + 1);
            else pass_count++;
        end
        check_count++;
        if (stall_count !== 16'd8) $display("[TB] FAIL distinct_stall: got %0d expected 8", stall_count);
        else pass_count++;
        step();
    endtask

    task automatic test_arb_disable();
        arb_enable = 1'b0;
        drive(1, 3, 9, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_count++;
            if (ready_vec() !== 4'b0000) $display("[TB] FAIL disable_ready_%0d: got %b expected 0000", k, ready_vec());
            else pass_count++;
            step();
            check_count++;
            if (strobe_vec() !== 32'h0) $display("[TB] FAIL disable_strobe_%0d: got %h expected 0", k, strobe_vec());
            else pass_count++;
        end
        check_count++;
        if (stall_count !== 16'd13) $display("[TB] FAIL disable_stall: got %0d expected 13", stall_count);
        else pass_count++;
        arb_enable = 1'b1;
        #1;
        check_count++;
        if (ready_vec() !== 4'b0010) $display("[TB] FAIL enable_ready: got %b expected 0010", ready_vec());
        else pass_count++;
        step();
        clear_requests();
        check_count++;
        if (strobe_vec() !== 32'h8 || bus.bank_data[3] !== 8'h5A || stall_count !== 16'd13)
            $display("[TB] FAIL enable_write: got strobe=%h data=%h stall=%0d expected 8/5a/13",
                     strobe_vec(), bus.bank_data[3], stall_count);
        else pass_count++;
        step();
    endtask

    task automatic test_saturation();
        arb_enable = 1'b0;
        drive(0, 4, 0, 8'h01);
        repeat (65540) @(posedge clk);
        #1;
        check_count++;
        if (stall_count !== 16'hFFFF) $display("[TB] FAIL sat_hold: got %h expected ffff", stall_count);
        else pass_count++;
        stall_clear = 1'b1;
        step();
        check_count++;
        if (stall_count !== 16'h0) $display("[TB] FAIL sat_clear: got %h expected 0", stall_count);
        else pass_count++;
        stall_clear = 1'b0;
        step();
        check_count++;
        if (stall_count !== 16'h1) $display("[TB] FAIL sat_resume: got %h expected 1", stall_count);
        else pass_count++;
        clear_requests();
        arb_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        drive(0, 9, 3, 8'h77);
        #1;
        check_count++;
        if (ready_vec() !== 4'b0001) $display("[TB] FAIL midrst_ready: got %b expected 0001", ready_vec());
        else pass_count++;
        step();
        clear_requests();
        check_count++;
        if (strobe_vec() !== 32'h200) $display("[TB] FAIL midrst_strobe_pre: got %h expected 200", strobe_vec());
        else pass_count++;
        #1;
        reset = 1'b1;
        #1;
        check_count++;
        if (strobe_vec() !== 32'h0 || bus.bank_data[9] !== 8'h0 || stall_count !== 16'h0)
            $display("[TB] FAIL midrst_drop: got strobe=%h data=%h stall=%0d expected 0/0/0",
                     strobe_vec(), bus.bank_data[9], stall_count);
        else pass_count++;
        step();
        check_count++;
        if (strobe_vec() !== 32'h0) $display("[TB] FAIL midrst_hold: got %h expected 0", strobe_vec());
        else pass_count++;
        reset = 1'b0;
        drive(0, 9, 5, 8'h88);
        drive(1, 9, 6, 8'h99);
        #1;
        check_count++;
        if (ready_vec() !== 4'b0001) $display("[TB] FAIL midrst_ptr: got %b expected 0001", ready_vec());
        else pass_count++;
        step();
        clear_requests();
        check_count++;
        if (strobe_vec() !== 32'h200 || bus.bank_data[9] !== 8'h88)
            $display("[TB] FAIL midrst_write: got strobe=%h data=%h expected 200/88", strobe_vec(), bus.bank_data[9]);
        else pass_count++;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_distinct_banks();
        test_arb_disable();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
